// File: rtl/cs_frame_ctrl.sv
// Frame sequencer for the CS comparator/selector: gates CS shifting on accepted
// samples, hides window warm-up results and hands Y downstream with back-pressure.
module cs_frame_ctrl #(
  parameter int unsigned WIN   = 9,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_data,
  output logic [7:0]       cs_x,
  output logic             cs_en,
  output logic             cs_clr,
  input  logic [9:0]       cs_y,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] out_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] C_WIN    = LEN_W'(WIN);
  localparam logic [LEN_W-1:0] C_WIN_M1 = LEN_W'(WIN - 1);
  localparam logic [LEN_W-1:0] C_ONE    = LEN_W'(1);

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_len, r_in_cnt, r_out_cnt;
  logic             r_out_valid, r_err;
  logic             w_acc, w_hs, w_short, w_fill_last, w_run_last;

  assign w_acc       = in_valid & in_ready;
  assign w_hs        = r_out_valid & out_ready;
  assign w_short     = frame_len < C_WIN;
  assign w_fill_last = w_acc & (r_in_cnt == C_WIN_M1);
  // Last result of a frame is number len-WIN+1.
  assign w_run_last  = w_hs & ((r_out_cnt + C_ONE) == (r_len - C_WIN_M1));

  assign cs_en     = w_acc;
  assign cs_x      = in_data;
  assign out_data  = cs_y;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign out_cnt   = r_out_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = w_short ? S_DONE : S_CLEAR;
        S_CLEAR: w_next = S_FILL;
        S_FILL:  if (w_fill_last) w_next = S_RUN;
        S_RUN:   if (w_run_last) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    cs_clr   = 1'b0;
    done     = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_CLEAR: cs_clr = 1'b1;
      S_FILL:  in_ready = 1'b1;
      // A new sample may only shift CS once the held result is leaving.
      S_RUN:   in_ready = (r_in_cnt < r_len) & (~r_out_valid | out_ready);
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len       <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (abort) begin
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len     <= frame_len;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_err     <= w_short;
          end
        end
        S_FILL: begin
          if (w_acc) r_in_cnt <= r_in_cnt + C_ONE;
          if (w_fill_last) r_out_valid <= 1'b1;
        end
        S_RUN: begin
          if (w_acc) begin
            r_in_cnt    <= r_in_cnt + C_ONE;
            r_out_valid <= 1'b1;
          end else if (w_hs) begin
            r_out_valid <= 1'b0;
          end
          if (w_hs) r_out_cnt <= r_out_cnt + C_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_frame_ctrl.sv
// Directed bench for cs_frame_ctrl; a stand-in CS produces Y = (sum of 9-sample window) >> 2.
module tb_cs_frame_ctrl;
  localparam int unsigned WIN   = 9;
  localparam int unsigned LEN_W = 16;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, cs_en, cs_clr, busy, done, err;
  logic [9:0] out_data, cs_y;
  logic [7:0] cs_x;
  logic [LEN_W-1:0] out_cnt;

  int n_cmp = 0, n_err = 0;
  logic [7:0] tx [0:31];
  logic [9:0] rx [$];
  int first_ov_acc, last_hs_cyc, done_cyc, n_acc_tot;
  logic [LEN_W-1:0] cnt_at_done;

  always #5 clk = ~clk;

  cs_frame_ctrl #(.WIN(WIN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cs_x(cs_x), .cs_en(cs_en), .cs_clr(cs_clr), .cs_y(cs_y),
    .busy(busy), .done(done), .err(err), .out_cnt(out_cnt)
  );

  logic [7:0]  win [0:7];
  logic [11:0] w_sum;
  always_comb begin
    w_sum = 12'(cs_x);
    for (int i = 0; i < 8; i++) w_sum = w_sum + 12'(win[i]);
  end
  always @(posedge clk or posedge reset) begin
    if (reset || cs_clr) begin
      for (int i = 0; i < 8; i++) win[i] <= '0;
      cs_y <= '0;
    end else if (cs_en) begin
      win[0] <= cs_x;
      for (int i = 1; i < 8; i++) win[i] <= win[i-1];
      cs_y <= 10'(w_sum >> 2);
    end
  end

  task automatic start_frame(input logic [LEN_W-1:0] len);
    @(posedge clk); #1 start = 1'b1; frame_len = len;
    @(posedge clk); #1 start = 1'b0; frame_len = '1;
    #1;
  endtask

  task automatic run_stream(input int stall_at, input int stall_len, input int budget);
    int n_acc, cyc, stall_left;
    logic [9:0] held;
    bit held_ok;
    n_acc = 0; cyc = 0; stall_left = stall_len; held = '0; held_ok = 0;
    rx.delete(); first_ov_acc = -1; last_hs_cyc = -1; done_cyc = -1; cnt_at_done = '0;
    while (cyc < budget && done_cyc < 0) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = tx[n_acc % 32]; out_ready = 1'b1;
      if (stall_left > 0 && rx.size() == stall_at && out_valid === 1'b1) begin
        out_ready = 1'b0; stall_left--;
      end
      #1;
      if (!out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0 || cs_en !== 1'b0) begin
          n_err++; $display("FAIL stall_gate in_ready=%b cs_en=%b expected 0/0", in_ready, cs_en);
        end
        if (held_ok) begin
          n_cmp++;
          if (out_data !== held) begin
            n_err++; $display("FAIL stall_data out_data=%h expected %h", out_data, held);
          end
        end
        held = out_data; held_ok = 1;
      end
      if (out_valid === 1'b1 && first_ov_acc < 0) first_ov_acc = n_acc;
      if (out_valid === 1'b1 && out_ready) begin rx.push_back(out_data); last_hs_cyc = cyc; end
      if (in_ready === 1'b1) n_acc++;
      if (done === 1'b1) begin done_cyc = cyc; cnt_at_done = out_cnt; end
      cyc++;
    end
    in_valid = 1'b0;
    n_acc_tot = n_acc;
    n_cmp++;
    if (done_cyc < 0) begin n_err++; $display("FAIL done_timeout no done within %0d cycles", budget); end
  endtask

  task automatic test_reset();
    #12 reset = 1'b0;
    @(posedge clk); #2;
    n_cmp++;
    if ({in_ready, out_valid, cs_en, cs_clr, busy, done, err} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags got %b expected 0000000",
                        {in_ready, out_valid, cs_en, cs_clr, busy, done, err});
    end
    n_cmp++;
    if (out_cnt !== '0) begin n_err++; $display("FAIL reset_cnt out_cnt=%0d expected 0", out_cnt); end
  endtask

  task automatic test_frame12();
    for (int i = 0; i < 32; i++) tx[i] = 8'h10;
    start_frame(16'd12);
    n_cmp++;
    if (cs_clr !== 1'b1) begin n_err++; $display("FAIL f12_clr cs_clr=%b expected 1", cs_clr); end
    run_stream(-1, 0, 60);
    n_cmp++;
    if (first_ov_acc !== 9) begin n_err++; $display("FAIL f12_first_ov after %0d samples expected 9", first_ov_acc); end
    n_cmp++;
    if (rx.size() !== 4) begin n_err++; $display("FAIL f12_count got %0d expected 4", rx.size()); end
    for (int i = 0; i < rx.size(); i++) begin
      n_cmp++;
      if (rx[i] !== 10'h024) begin n_err++; $display("FAIL f12_data[%0d] got %h expected 024", i, rx[i]); end
    end
    n_cmp++;
    if (done_cyc !== last_hs_cyc + 1 || done_cyc !== 13) begin
      n_err++; $display("FAIL f12_done_timing done at %0d last hs %0d expected 13/12", done_cyc, last_hs_cyc);
    end
    n_cmp++;
    if (cnt_at_done !== 16'd4) begin n_err++; $display("FAIL f12_out_cnt got %0d expected 4", cnt_at_done); end
    n_cmp++;
    if (n_acc_tot !== 12) begin n_err++; $display("FAIL f12_accepted got %0d expected 12", n_acc_tot); end
  endtask

  task automatic test_frame9();
    for (int i = 0; i < 32; i++) tx[i] = 8'(i);
    start_frame(16'd9);
    run_stream(-1, 0, 40);
    n_cmp++;
    if (rx.size() !== 1 || rx[0] !== 10'h009) begin
      n_err++; $display("FAIL f9_result count %0d first %h expected 1 / 009", rx.size(), rx.size() > 0 ? rx[0] : 10'h3ff);
    end
    n_cmp++;
    if (cnt_at_done !== 16'd1) begin n_err++; $display("FAIL f9_out_cnt got %0d expected 1", cnt_at_done); end
    @(posedge clk); #2;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL f9_busy_drop busy=%b expected 0", busy); end
  endtask

  task automatic test_stall();
    logic [9:0] exp_v [6];
    exp_v = '{10'd9, 10'd11, 10'd13, 10'd15, 10'd18, 10'd20};
    for (int i = 0; i < 32; i++) tx[i] = 8'(i);
    start_frame(16'd14);
    run_stream(2, 5, 80);
    n_cmp++;
    if (rx.size() !== 6) begin n_err++; $display("FAIL stall_count got %0d expected 6", rx.size()); end
    for (int i = 0; i < 6 && i < rx.size(); i++) begin
      n_cmp++;
      if (rx[i] !== exp_v[i]) begin n_err++; $display("FAIL stall_result[%0d] got %0d expected %0d", i, rx[i], exp_v[i]); end
    end
    n_cmp++;
    if (cnt_at_done !== 16'd6) begin n_err++; $display("FAIL stall_out_cnt got %0d expected 6", cnt_at_done); end
  endtask

  task automatic test_short();
    start_frame(16'd5);
    in_valid = 1'b1;
    #0;
    n_cmp++;
    if ({done, err, cs_clr, in_ready} !== 4'b1100) begin
      n_err++; $display("FAIL short_done done/err/clr/ready=%b expected 1100", {done, err, cs_clr, in_ready});
    end
    @(posedge clk); #2;
    n_cmp++;
    if ({busy, err, cs_clr, in_ready} !== 4'b0100) begin
      n_err++; $display("FAIL short_after busy/err/clr/ready=%b expected 0100", {busy, err, cs_clr, in_ready});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    bit saw_done;
    logic [9:0] exp_v [2];
    exp_v = '{10'h051, 10'h053};
    start_frame(16'd20);
    n_cmp++;
    if ({cs_clr, err} !== 2'b10) begin n_err++; $display("FAIL abort_start clr/err=%b expected 10", {cs_clr, err}); end
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h10; out_ready = 1'b1;
      #1 if (in_ready === 1'b1) n++;
    end
    @(posedge clk); #1 abort = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 abort = 1'b0;
    #1;
    n_cmp++;
    if ({busy, out_valid, done} !== 3'b000) begin
      n_err++; $display("FAIL abort_idle busy/ov/done=%b expected 000", {busy, out_valid, done});
    end
    saw_done = 0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #2 if (done !== 1'b0) saw_done = 1; end
    n_cmp++;
    if (saw_done) begin n_err++; $display("FAIL abort_no_done done seen=1 expected 0"); end
    for (int i = 0; i < 32; i++) tx[i] = 8'(8'h20 + i);
    start_frame(16'd10);
    n_cmp++;
    if (cs_clr !== 1'b1) begin n_err++; $display("FAIL abort_restart_clr cs_clr=%b expected 1", cs_clr); end
    run_stream(-1, 0, 40);
    n_cmp++;
    if (rx.size() !== 2) begin n_err++; $display("FAIL abort_count got %0d expected 2", rx.size()); end
    for (int i = 0; i < 2 && i < rx.size(); i++) begin
      n_cmp++;
      if (rx[i] !== exp_v[i]) begin n_err++; $display("FAIL abort_result[%0d] got %h expected %h", i, rx[i], exp_v[i]); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 32; i++) tx[i] = 8'h10;
    start_frame(16'd12);
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h10; out_ready = 1'b0;
    end
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_setup out_valid=%b expected 1", out_valid); end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, busy} !== 3'b000) begin
      n_err++; $display("FAIL areset_drop ov/ready/busy=%b expected 000", {out_valid, in_ready, busy});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #10 reset = 1'b0;
    n_cmp++;
    if (out_cnt !== '0) begin n_err++; $display("FAIL areset_cnt out_cnt=%0d expected 0", out_cnt); end
    for (int i = 0; i < 32; i++) tx[i] = 8'(i);
    start_frame(16'd9);
    run_stream(-1, 0, 40);
    n_cmp++;
    if (rx.size() !== 1 || rx[0] !== 10'h009 || cnt_at_done !== 16'd1) begin
      n_err++; $display("FAIL areset_fresh count %0d cnt %0d expected 1 result 009", rx.size(), cnt_at_done);
    end
  endtask

  initial begin
    test_reset();
    test_frame12();
    test_frame9();
    test_stall();
    test_short();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
